// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt controller for the 5-stage MIPS pipeline.
// Drives PC/IF/ID/ID/EX controls, ALU forward selects and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned RA_W       = 5,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  rs_D,
  input  logic [RA_W-1:0]  rt_D,
  input  logic             usesRt_D,
  input  logic             syscall_D,
  input  logic             syscall_W,
  input  logic [RA_W-1:0]  rs_E,
  input  logic [RA_W-1:0]  rt_E,
  input  logic [RA_W-1:0]  writeReg_E,
  input  logic             memRead_E,
  input  logic             pcSrc_E,
  input  logic [RA_W-1:0]  writeReg_M,
  input  logic [RA_W-1:0]  writeReg_W,
  input  logic             regWrite_M,
  input  logic             regWrite_W,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExFlush,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             halted,
  output logic [CNT_W-1:0] cycleCount,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam int unsigned RemW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
  localparam logic [RemW-1:0] RemInit = RemW'(LOAD_STALL - 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e            state_q;
  logic [RemW-1:0]   stallRemain_q;
  logic              hazard;
  logic              stall;

  logic              fwdMA, fwdWA, fwdMB, fwdWB;

  assign fwdMA = regWrite_M && (writeReg_M != '0) && (writeReg_M == rs_E);
  assign fwdWA = regWrite_W && (writeReg_W != '0) && (writeReg_W == rs_E);
  assign fwdMB = regWrite_M && (writeReg_M != '0) && (writeReg_M == rt_E);
  assign fwdWB = regWrite_W && (writeReg_W != '0) && (writeReg_W == rt_E);

  // Memory stage holds the newer value, so it wins over Write Back.
  assign fwdA = fwdMA ? 2'b10 : (fwdWA ? 2'b01 : 2'b00);
  assign fwdB = fwdMB ? 2'b10 : (fwdWB ? 2'b01 : 2'b00);

  assign hazard = memRead_E && (writeReg_E != '0) &&
                  ((writeReg_E == rs_D) || (usesRt_D && (writeReg_E == rt_D)));

  assign stall = (hazard || (stallRemain_q != '0)) && !pcSrc_E && (state_q == StRun);

  // Controls depend on same-cycle hazard/branch inputs, so they are decoded from state here.
  always_comb begin
    pcWrite   = 1'b1;
    ifIdWrite = 1'b1;
    ifIdFlush = 1'b0;
    idExFlush = 1'b0;
    halted    = 1'b0;
    if (reset) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (pcSrc_E) begin
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
          end else if (stall) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
          end
        end
        StDrain: begin
          pcWrite   = 1'b0;
          ifIdFlush = 1'b1;
        end
        default: begin
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          ifIdFlush = 1'b1;
          idExFlush = 1'b1;
          halted    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      stallRemain_q <= '0;
      cycleCount    <= '0;
      stallCount    <= '0;
      flushCount    <= '0;
    end else begin
      unique case (state_q)
        StRun:   if (syscall_D && !pcSrc_E && !stall) state_q <= StDrain;
        StDrain: if (syscall_W) state_q <= StHalted;
        default: ;
      endcase

      if (pcSrc_E) begin
        stallRemain_q <= '0;
      end else if (hazard && (state_q == StRun)) begin
        stallRemain_q <= RemInit;
      end else if (stallRemain_q != '0) begin
        stallRemain_q <= stallRemain_q - 1'b1;
      end

      if (state_q != StHalted) begin
        if (cycleCount != '1) cycleCount <= cycleCount + 1'b1;
        if (stall && (stallCount != '1)) stallCount <= stallCount + 1'b1;
        if (pcSrc_E && (flushCount != '1)) flushCount <= flushCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for forwarding/hazard decode,
// hand sequences for multi-cycle stall, branch, halt and counter saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, writeReg_E, writeReg_M, writeReg_W;
  logic       usesRt_D, syscall_D, syscall_W, memRead_E, pcSrc_E, regWrite_M, regWrite_W;

  logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush, halted;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] cycleCount, stallCount, flushCount;

  logic        l3PcWrite, l3IfIdWrite, l3IfIdFlush, l3IdExFlush, l3Halted;
  logic [1:0]  l3FwdA, l3FwdB;
  logic [15:0] l3Cycle, l3Stall, l3Flush;

  logic        sPcWrite, sIfIdWrite, sIfIdFlush, sIdExFlush, sHalted;
  logic [1:0]  sFwdA, sFwdB;
  logic [3:0]  sCycle, sStall, sFlush;

  int nVec  = 0;
  int nFail = 0;
  int stallCycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .usesRt_D(usesRt_D),
    .syscall_D(syscall_D), .syscall_W(syscall_W), .rs_E(rs_E), .rt_E(rt_E),
    .writeReg_E(writeReg_E), .memRead_E(memRead_E), .pcSrc_E(pcSrc_E),
    .writeReg_M(writeReg_M), .writeReg_W(writeReg_W), .regWrite_M(regWrite_M),
    .regWrite_W(regWrite_W), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
    .ifIdFlush(ifIdFlush), .idExFlush(idExFlush), .fwdA(fwdA), .fwdB(fwdB),
    .halted(halted), .cycleCount(cycleCount), .stallCount(stallCount),
    .flushCount(flushCount)
  );

  pipe_hazard_ctrl #(.LOAD_STALL(3)) u_ls3 (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .usesRt_D(usesRt_D),
    .syscall_D(syscall_D), .syscall_W(syscall_W), .rs_E(rs_E), .rt_E(rt_E),
    .writeReg_E(writeReg_E), .memRead_E(memRead_E), .pcSrc_E(pcSrc_E),
    .writeReg_M(writeReg_M), .writeReg_W(writeReg_W), .regWrite_M(regWrite_M),
    .regWrite_W(regWrite_W), .pcWrite(l3PcWrite), .ifIdWrite(l3IfIdWrite),
    .ifIdFlush(l3IfIdFlush), .idExFlush(l3IdExFlush), .fwdA(l3FwdA), .fwdB(l3FwdB),
    .halted(l3Halted), .cycleCount(l3Cycle), .stallCount(l3Stall),
    .flushCount(l3Flush)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .usesRt_D(usesRt_D),
    .syscall_D(syscall_D), .syscall_W(syscall_W), .rs_E(rs_E), .rt_E(rt_E),
    .writeReg_E(writeReg_E), .memRead_E(memRead_E), .pcSrc_E(pcSrc_E),
    .writeReg_M(writeReg_M), .writeReg_W(writeReg_W), .regWrite_M(regWrite_M),
    .regWrite_W(regWrite_W), .pcWrite(sPcWrite), .ifIdWrite(sIfIdWrite),
    .ifIdFlush(sIfIdFlush), .idExFlush(sIdExFlush), .fwdA(sFwdA), .fwdB(sFwdB),
    .halted(sHalted), .cycleCount(sCycle), .stallCount(sStall),
    .flushCount(sFlush)
  );

  typedef struct {
    logic [4:0] rsE, rtE, wrM, wrW, wrE, rsD, rtD;
    logic       rwM, rwW, memRd, usesRt, pcSrc;
    logic [1:0] fA, fB;
    logic       pcW, ifW, ifF, idF;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rsE, rtE, wrM, input logic rwM,
                              input logic [4:0] wrW, input logic rwW, input logic memRd,
                              input logic [4:0] wrE, rsD, rtD, input logic usesRt, pcSrc,
                              input logic [1:0] fA, fB, input logic pcW, ifW, ifF, idF);
    vec_t v;
    v.rsE = rsE; v.rtE = rtE; v.wrM = wrM; v.rwM = rwM; v.wrW = wrW; v.rwW = rwW;
    v.memRd = memRd; v.wrE = wrE; v.rsD = rsD; v.rtD = rtD; v.usesRt = usesRt;
    v.pcSrc = pcSrc; v.fA = fA; v.fB = fB; v.pcW = pcW; v.ifW = ifW; v.ifF = ifF; v.idF = idF;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_D = 0; rt_D = 0; usesRt_D = 0; syscall_D = 0; syscall_W = 0;
    rs_E = 0; rt_E = 0; writeReg_E = 0; memRead_E = 0; pcSrc_E = 0;
    writeReg_M = 0; writeReg_W = 0; regWrite_M = 0; regWrite_W = 0;
  endtask

  task automatic doReset();
    idle();
    reset = 1'b1;
    #1;
    chk("rst_pcWrite", 32'(pcWrite), 0);
    chk("rst_ifIdWrite", 32'(ifIdWrite), 0);
    chk("rst_ifIdFlush", 32'(ifIdFlush), 1);
    chk("rst_idExFlush", 32'(idExFlush), 1);
    chk("rst_halted", 32'(halted), 0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic setHazard(input logic on);
    memRead_E = on; writeReg_E = 5'd8; rt_D = 5'd8; usesRt_D = 1'b1;
  endtask

  vec_t vecs[10];

  initial begin
    //               rsE rtE wrM rwM wrW rwW mR wrE rsD rtD uRt br  fA     fB     pcW ifW ifF idF
    vecs[0] = mk(9,  0,  9,  1,  9,  1,  0, 0,  0,  0,  0,  0, 2'b10, 2'b00, 1, 1, 0, 0);
    vecs[1] = mk(9,  0,  0,  1,  9,  1,  0, 0,  0,  0,  0,  0, 2'b01, 2'b00, 1, 1, 0, 0);
    vecs[2] = mk(0,  5,  5,  0,  5,  1,  0, 0,  0,  0,  0,  0, 2'b00, 2'b01, 1, 1, 0, 0);
    vecs[3] = mk(3,  3,  3,  1,  7,  1,  0, 0,  0,  0,  0,  0, 2'b10, 2'b10, 1, 1, 0, 0);
    vecs[4] = mk(0,  0,  0,  0,  0,  0,  1, 8,  0,  8,  1,  0, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[5] = mk(0,  0,  0,  0,  0,  0,  1, 8,  0,  8,  0,  0, 2'b00, 2'b00, 1, 1, 0, 0);
    vecs[6] = mk(0,  0,  0,  0,  0,  0,  1, 8,  8,  0,  0,  0, 2'b00, 2'b00, 0, 0, 0, 1);
    vecs[7] = mk(0,  0,  0,  0,  0,  0,  1, 0,  0,  0,  1,  0, 2'b00, 2'b00, 1, 1, 0, 0);
    vecs[8] = mk(0,  0,  0,  0,  0,  0,  1, 8,  8,  8,  1,  1, 2'b00, 2'b00, 1, 1, 1, 1);
    vecs[9] = mk(4,  6,  4,  1,  6,  0,  0, 0,  0,  0,  0,  0, 2'b10, 2'b00, 1, 1, 0, 0);

    doReset();
    chk("post_rst_cycle", 32'(cycleCount), 0);
    chk("post_rst_stall", 32'(stallCount), 0);
    chk("post_rst_flush", 32'(flushCount), 0);
    chk("post_rst_pcWrite", 32'(pcWrite), 1);

    for (int i = 0; i < 10; i++) begin
      rs_E = vecs[i].rsE; rt_E = vecs[i].rtE; writeReg_M = vecs[i].wrM;
      regWrite_M = vecs[i].rwM; writeReg_W = vecs[i].wrW; regWrite_W = vecs[i].rwW;
      memRead_E = vecs[i].memRd; writeReg_E = vecs[i].wrE; rs_D = vecs[i].rsD;
      rt_D = vecs[i].rtD; usesRt_D = vecs[i].usesRt; pcSrc_E = vecs[i].pcSrc;
      #1;
      chk($sformatf("v%0d_fwdA", i), 32'(fwdA), 32'(vecs[i].fA));
      chk($sformatf("v%0d_fwdB", i), 32'(fwdB), 32'(vecs[i].fB));
      chk($sformatf("v%0d_pcWrite", i), 32'(pcWrite), 32'(vecs[i].pcW));
      chk($sformatf("v%0d_ifIdWrite", i), 32'(ifIdWrite), 32'(vecs[i].ifW));
      chk($sformatf("v%0d_ifIdFlush", i), 32'(ifIdFlush), 32'(vecs[i].ifF));
      chk($sformatf("v%0d_idExFlush", i), 32'(idExFlush), 32'(vecs[i].idF));
      tick();
    end

    // Single-bubble load-use with LOAD_STALL=1.
    doReset();
    setHazard(1'b1);
    #1;
    chk("ls1_pcWrite", 32'(pcWrite), 0);
    chk("ls1_idExFlush", 32'(idExFlush), 1);
    tick();
    idle();
    #1;
    chk("ls1_release", 32'(pcWrite), 1);
    chk("ls1_stallCount", 32'(stallCount), 1);

    // LOAD_STALL=3: one hazard pulse holds the PC for three cycles.
    doReset();
    stallCycles = 0;
    setHazard(1'b1);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (!l3PcWrite) stallCycles++;
      tick();
      idle();
    end
    chk("ls3_stall_cycles", 32'(stallCycles), 3);
    chk("ls3_stallCount", 32'(l3Stall), 3);

    // Branch in the middle of a multi-cycle stall clears the remaining bubbles.
    doReset();
    setHazard(1'b1);
    tick();
    pcSrc_E = 1'b1;
    #1;
    chk("br_pcWrite", 32'(l3PcWrite), 1);
    chk("br_ifIdFlush", 32'(l3IfIdFlush), 1);
    chk("br_idExFlush", 32'(l3IdExFlush), 1);
    tick();
    idle();
    #1;
    chk("br_remain_clear", 32'(l3PcWrite), 1);
    chk("br_stallCount", 32'(l3Stall), 1);
    chk("br_flushCount", 32'(l3Flush), 1);

    // Syscall drain/halt sequence; cycle 0 is the first cycle after reset.
    doReset();
    repeat (3) tick();
    syscall_D = 1'b1; pcSrc_E = 1'b1;
    tick();
    idle();
    #1;
    chk("flushed_sys_run", 32'(ifIdFlush), 0);
    chk("cycle4_count", 32'(cycleCount), 4);
    tick();
    syscall_W = 1'b1;
    tick();
    idle();
    #1;
    chk("sysW_in_run", 32'(halted), 0);
    chk("sysW_in_run_pc", 32'(pcWrite), 1);
    repeat (4) tick();
    syscall_D = 1'b1;
    #1;
    chk("c10_pcWrite", 32'(pcWrite), 1);
    tick();
    idle();
    #1;
    chk("drain_pcWrite", 32'(pcWrite), 0);
    chk("drain_ifIdWrite", 32'(ifIdWrite), 1);
    chk("drain_ifIdFlush", 32'(ifIdFlush), 1);
    chk("drain_idExFlush", 32'(idExFlush), 0);
    tick();
    tick();
    syscall_W = 1'b1;
    #1;
    chk("c13_halted", 32'(halted), 0);
    tick();
    idle();
    #1;
    chk("c14_halted", 32'(halted), 1);
    chk("c14_cycle", 32'(cycleCount), 14);
    chk("halt_idExFlush", 32'(idExFlush), 1);
    repeat (5) tick();
    chk("halt_frozen", 32'(cycleCount), 14);
    chk("halt_stays", 32'(halted), 1);
    doReset();
    chk("unhalt", 32'(halted), 0);
    chk("unhalt_cycle", 32'(cycleCount), 0);
    chk("unhalt_flush", 32'(flushCount), 0);

    // Saturation on the 4-bit counter instance.
    repeat (20) tick();
    chk("sat_cycle", 32'(sCycle), 15);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
